sine_rom: RTL and testbench

- Synchronous 256-entry by 8-bit lookup ROM holding one full period of an offset-binary sine wave.
- Sits under the sine generator, which advances an 8-bit phase counter and drives the ROM address.
- The sample output feeds the DAC path. The generator derives its period, conversion-strobe and half-cycle flags from the ROM output.

---
 rtl/sine_rom_pkg.sv | 49 ++++
 rtl/sine_rom.sv | 24 ++
 tb/tb_sine_rom.sv | 137 +++++++++++++
 3 files changed

// File: rtl/sine_rom_pkg.sv
// rtl/sine_rom_pkg.sv - shared constants and quarter-wave lookup for the sine ROM
package sine_rom_pkg;

    localparam int SINE_ADDR_W = 8;
    localparam int SINE_DATA_W = 8;
    localparam int SINE_DEPTH  = 256;

    localparam logic [SINE_DATA_W-1:0] SINE_MID = 8'd128;
    localparam logic [SINE_DATA_W-1:0] SINE_MAX = 8'd255;
    localparam logic [SINE_DATA_W-1:0] SINE_MIN = 8'd1;

    // Rising quarter, round(128 + 127*sin(2*pi*i/256)) for i = 0..64.
    function automatic logic [SINE_DATA_W-1:0] sine_quarter(input logic [6:0] idx);
        logic [SINE_DATA_W-1:0] v;
        case (idx)
            7'd0:  v = 8'd128;  7'd1:  v = 8'd131;  7'd2:  v = 8'd134;  7'd3:  v = 8'd137;
            7'd4:  v = 8'd140;  7'd5:  v = 8'd144;  7'd6:  v = 8'd147;  7'd7:  v = 8'd150;
            7'd8:  v = 8'd153;  7'd9:  v = 8'd156;  7'd10: v = 8'd159;  7'd11: v = 8'd162;
            7'd12: v = 8'd165;  7'd13: v = 8'd168;  7'd14: v = 8'd171;  7'd15: v = 8'd174;
            7'd16: v = 8'd177;  7'd17: v = 8'd179;  7'd18: v = 8'd182;  7'd19: v = 8'd185;
            7'd20: v = 8'd188;  7'd21: v = 8'd191;  7'd22: v = 8'd193;  7'd23: v = 8'd196;
            7'd24: v = 8'd199;  7'd25: v = 8'd201;  7'd26: v = 8'd204;  7'd27: v = 8'd206;
            7'd28: v = 8'd209;  7'd29: v = 8'd211;  7'd30: v = 8'd213;  7'd31: v = 8'd216;
            7'd32: v = 8'd218;  7'd33: v = 8'd220;  7'd34: v = 8'd222;  7'd35: v = 8'd224;
            7'd36: v = 8'd226;  7'd37: v = 8'd228;  7'd38: v = 8'd230;  7'd39: v = 8'd232;
            7'd40: v = 8'd234;  7'd41: v = 8'd235;  7'd42: v = 8'd237;  7'd43: v = 8'd239;
            7'd44: v = 8'd240;  7'd45: v = 8'd241;  7'd46: v = 8'd243;  7'd47: v = 8'd244;
            7'd48: v = 8'd245;  7'd49: v = 8'd246;  7'd50: v = 8'd248;  7'd51: v = 8'd249;
            7'd52: v = 8'd250;  7'd53: v = 8'd250;  7'd54: v = 8'd251;  7'd55: v = 8'd252;
            7'd56: v = 8'd253;  7'd57: v = 8'd253;  7'd58: v = 8'd254;  7'd59: v = 8'd254;
            7'd60: v = 8'd254;  7'd61: v = 8'd255;  7'd62: v = 8'd255;  7'd63: v = 8'd255;
            7'd64: v = 8'd255;
            default: v = SINE_MAX;
        endcase
        return v;
    endfunction

    // Mirror the quarter about phase 64, then negate about 256 for the lower half-cycle.
    function automatic logic [SINE_DATA_W-1:0] sine_lookup(input logic [SINE_ADDR_W-1:0] addr);
        logic [6:0]             phase;
        logic [6:0]             idx;
        logic [SINE_DATA_W-1:0] mag;
        phase = addr[6:0];
        idx   = (phase > 7'd64) ? (7'd0 - phase) : phase;
        mag   = sine_quarter(idx);
        return addr[7] ? (8'd0 - mag) : mag;
    endfunction

endpackage

// File: rtl/sine_rom.sv
// rtl/sine_rom.sv - 256 x 8 offset-binary sine ROM with registered address
module sine_rom
    import sine_rom_pkg::*;
(
    input  logic                   clock,
    input  logic                   rst,
    input  logic [SINE_ADDR_W-1:0] address,
    output logic [SINE_DATA_W-1:0] q
);

    logic [SINE_ADDR_W-1:0] addr_q;

    // Clearing the address (not q) makes reset land on midscale without a separate output mux.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            addr_q <= '0;
        end else begin
            addr_q <= address;
        end
    end

    assign q = sine_lookup(addr_q);

endmodule

// File: tb/tb_sine_rom.sv
// tb/tb_sine_rom.sv - self-checking bench for sine_rom
module tb_sine_rom;

    logic       clock;
    logic       rst;
    logic [7:0] address;
    logic [7:0] q;

    int n_compared;
    int n_mismatched;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] exp;
    } vec_t;

    vec_t       vecs[15];
    logic [7:0] sweep[256];

    sine_rom dut (
        .clock   (clock),
        .rst     (rst),
        .address (address),
        .q       (q)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [7:0] ref_sine(input int a);
        real v;
        v = 128.0 + 127.0 * $sin(2.0 * 3.14159265358979 * a / 256.0);
        return 8'($rtoi($floor(v + 0.5)));
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic [7:0] a);
        address = a;
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [7:0] mn;
        logic [7:0] mx;
        logic [7:0] ra;
        n_compared   = 0;
        n_mismatched = 0;

        vecs[0]  = '{8'd0,   8'd128};  vecs[1]  = '{8'd1,   8'd131};
        vecs[2]  = '{8'd2,   8'd134};  vecs[3]  = '{8'd64,  8'd255};
        vecs[4]  = '{8'd192, 8'd1};    vecs[5]  = '{8'd5,   8'd144};
        vecs[6]  = '{8'd32,  8'd218};  vecs[7]  = '{8'd96,  8'd218};
        vecs[8]  = '{8'd128, 8'd128};  vecs[9]  = '{8'd129, 8'd125};
        vecs[10] = '{8'd160, 8'd38};   vecs[11] = '{8'd254, 8'd122};
        vecs[12] = '{8'd255, 8'd125};  vecs[13] = '{8'd0,   8'd128};
        vecs[14] = '{8'd1,   8'd131};

        rst     = 1'b0;
        address = 8'd64;
        #2;
        check("reset_async", q, 8'd128);
        repeat (4) begin
            @(posedge clock);
            #1;
            check("reset_hold", q, 8'd128);
            n_compared++;
            if ($isunknown(q)) begin
                n_mismatched++;
                $display("FAIL reset_x: got %b expected no X", q);
            end
        end
        rst = 1'b1;
        step(8'd64);
        check("post_reset_64", q, 8'd255);

        for (int i = 0; i < 15; i++) begin
            step(vecs[i].addr);
            check($sformatf("anchor_%0d", vecs[i].addr), q, vecs[i].exp);
        end

        for (int a = 0; a < 256; a++) begin
            step(8'(a));
            sweep[a] = q;
            check($sformatf("sweep_%0d", a), q, ref_sine(a));
        end
        for (int k = 1; k < 128; k++)
            check($sformatf("sym_half_%0d", k), sweep[128 + k], 8'(256 - int'(sweep[k])));
        for (int k = 0; k <= 64; k++)
            check($sformatf("sym_quarter_%0d", k), sweep[64 - k], sweep[64 + k]);
        mn = 8'd255;
        mx = 8'd0;
        for (int a = 0; a < 256; a++) begin
            if (sweep[a] < mn) mn = sweep[a];
            if (sweep[a] > mx) mx = sweep[a];
        end
        check("sweep_min", mn, 8'd1);
        check("sweep_max", mx, 8'd255);

        step(8'd100);
        check("mid_reset_pre", q, 8'd209);
        #2;
        rst = 1'b0;
        #1;
        check("mid_reset_async", q, 8'd128);
        #2;
        rst = 1'b1;
        step(8'd101);
        check("mid_reset_resume", q, 8'd206);

        step(8'd160);
        for (int i = 0; i < 10; i++) begin
            @(posedge clock);
            #1;
            check("hold_160", q, 8'd38);
        end

        for (int i = 0; i < 300; i++) begin
            ra = 8'($urandom_range(0, 255));
            step(ra);
            check($sformatf("random_%0d", ra), q, ref_sine(int'(ra)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
